// File: rtl/rom_stream_loader.sv
// Byte-stream program loader: unpacks a framed image from a valid/ready byte channel,
// packs bytes little-endian into 32-bit words, writes them to the instruction ROM from
// word 0 and holds the core in reset until a checksummed frame has been fully loaded.
module rom_stream_loader #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  restart_i,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_data_i,
  output logic                  rx_ready_o,
  output logic                  rom_we_o,
  output logic [ADDR_WIDTH-1:0] rom_waddr_o,
  output logic [31:0]           rom_wdata_o,
  output logic                  core_rst_n_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CntW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    StSync, StLen0, StLen1, StData, StCsum, StDone, StError
  } state_e;

  state_e                r_state;
  logic [7:0]            r_len_lo;
  logic [15:0]           r_len;
  logic [1:0]            r_lane;
  logic [23:0]           r_shift;
  logic [CntW-1:0]       r_wcnt;
  logic [7:0]            r_xor;
  logic [TmoW-1:0]       r_tmo;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [31:0]           r_wdata;
  logic                  r_core_rst_n;
  logic                  r_done;
  logic                  r_err;
  logic [1:0]            r_err_code;

  logic                  w_acc;
  logic [15:0]           w_len;
  logic                  w_len_over;
  logic [CntW-1:0]       w_wcnt_inc;
  logic                  w_last_word;
  logic                  w_tmo_run;
  logic                  w_tmo_hit;

  // Byte channel is ready everywhere except the two terminal states.
  always_comb begin
    rx_ready_o = (r_state != StDone) && (r_state != StError);
  end

  // Decode helpers for the FSM: handshake, length limit, last word and timeout.
  always_comb begin
    w_acc       = rx_valid_i & rx_ready_o;
    w_len       = {rx_data_i, r_len_lo};
    // Word counter is one bit wider than the address so a full-capacity image is legal.
    w_len_over  = 32'(w_len) > (32'd1 << ADDR_WIDTH);
    w_wcnt_inc  = r_wcnt + CntW'(1);
    w_last_word = 32'(w_wcnt_inc) == 32'(r_len);
    w_tmo_run   = (r_state == StLen0) || (r_state == StLen1) ||
                  (r_state == StData) || (r_state == StCsum);
    w_tmo_hit   = r_tmo == TmoW'(TIMEOUT_CYCLES - 1);
  end

  // Frame FSM with registered ROM-write and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StSync;
      r_len_lo     <= '0;
      r_len        <= '0;
      r_lane       <= '0;
      r_shift      <= '0;
      r_wcnt       <= '0;
      r_xor        <= '0;
      r_tmo        <= '0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_core_rst_n <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= '0;
    end else begin
      r_we <= 1'b0;
      // Address advances after each strobe; wraps only after the final word.
      if (r_we) r_waddr <= r_waddr + ADDR_WIDTH'(1);

      if (restart_i) begin
        // Restart beats timeout, the checksum decision and any same-cycle byte.
        r_state      <= StSync;
        r_done       <= 1'b0;
        r_err        <= 1'b0;
        r_err_code   <= '0;
        r_core_rst_n <= 1'b0;
        r_waddr      <= '0;
        r_tmo        <= '0;
      end else begin
        if (!w_tmo_run || w_acc) begin
          r_tmo <= '0;
        end else if (!w_tmo_hit) begin
          r_tmo <= r_tmo + TmoW'(1);
        end

        if (w_tmo_run && !w_acc && w_tmo_hit) begin
          r_state    <= StError;
          r_err      <= 1'b1;
          r_err_code <= 2'd3;
        end else if (w_acc) begin
          unique case (r_state)
            StSync: begin
              if (rx_data_i == SYNC_BYTE) begin
                r_state <= StLen0;
                r_xor   <= '0;
                r_wcnt  <= '0;
                r_lane  <= '0;
                r_waddr <= '0;
              end
            end
            StLen0: begin
              r_len_lo <= rx_data_i;
              r_state  <= StLen1;
            end
            StLen1: begin
              r_len <= w_len;
              if (w_len_over) begin
                r_state    <= StError;
                r_err      <= 1'b1;
                r_err_code <= 2'd2;
              end else if (w_len == 16'd0) begin
                r_state <= StCsum;
              end else begin
                r_state <= StData;
              end
            end
            StData: begin
              r_xor  <= r_xor ^ rx_data_i;
              r_lane <= r_lane + 2'd1;
              unique case (r_lane)
                2'd0: r_shift[7:0]   <= rx_data_i;
                2'd1: r_shift[15:8]  <= rx_data_i;
                2'd2: r_shift[23:16] <= rx_data_i;
                2'd3: begin
                  r_wdata <= {rx_data_i, r_shift};
                  r_we    <= 1'b1;
                  r_wcnt  <= w_wcnt_inc;
                  if (w_last_word) r_state <= StCsum;
                end
                default: ;
              endcase
            end
            StCsum: begin
              if (rx_data_i == r_xor) begin
                r_state      <= StDone;
                r_done       <= 1'b1;
                r_core_rst_n <= 1'b1;
              end else begin
                r_state    <= StError;
                r_err      <= 1'b1;
                r_err_code <= 2'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign rom_we_o     = r_we;
  assign rom_waddr_o  = r_waddr;
  assign rom_wdata_o  = r_wdata;
  assign core_rst_n_o = r_core_rst_n;
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign err_code_o   = r_err_code;

endmodule

// File: tb/tb_rom_stream_loader.sv
// Directed bench for rom_stream_loader with a 16-word ROM and a 50-cycle byte timeout.
module tb_rom_stream_loader;

  localparam int unsigned Aw  = 4;
  localparam int unsigned Tmo = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic          restart_i;
  logic          rx_valid_i;
  logic [7:0]    rx_data_i;
  logic          rx_ready_o;
  logic          rom_we_o;
  logic [Aw-1:0] rom_waddr_o;
  logic [31:0]   rom_wdata_o;
  logic          core_rst_n_o;
  logic          done_o;
  logic          err_o;
  logic [1:0]    err_code_o;

  int n_tests = 0;
  int n_fail  = 0;

  rom_stream_loader #(
    .ADDR_WIDTH    (Aw),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .restart_i   (restart_i),
    .rx_valid_i  (rx_valid_i),
    .rx_data_i   (rx_data_i),
    .rx_ready_o  (rx_ready_o),
    .rom_we_o    (rom_we_o),
    .rom_waddr_o (rom_waddr_o),
    .rom_wdata_o (rom_wdata_o),
    .core_rst_n_o(core_rst_n_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .err_code_o  (err_code_o)
  );

  always #5 clk = ~clk;

  // Write monitor: records every ROM strobe and counts back-to-back strobes.
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          b2b = 0;
  logic        prev_we = 1'b0;
  always @(negedge clk) begin
    if (rom_we_o) begin
      wa_q.push_back(32'(rom_waddr_o));
      wd_q.push_back(rom_wdata_o);
      if (prev_we) b2b++;
    end
    prev_we = rom_we_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_a(input int i);
    return (i < wa_q.size()) ? wa_q[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] get_d(input int i);
    return (i < wd_q.size()) ? wd_q[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    @(posedge clk);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic pulse_restart();
    restart_i = 1'b1;
    @(posedge clk);
    #1;
    restart_i = 1'b0;
    wa_q.delete();
    wd_q.delete();
  endtask

  // Two-word frame; data XOR is 13^93^10 = 90.
  task automatic send_frame1(input logic [7:0] csum);
    logic [7:0] f [11];
    f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    for (int i = 0; i < 11; i++) send_byte(f[i]);
    send_byte(csum);
  endtask

  task automatic check_frame1_words(input string t);
    check({t, "_nwr"}, 32'(wa_q.size()), 32'd2);
    check({t, "_a0"}, get_a(0), 32'd0);
    check({t, "_d0"}, get_d(0), 32'h0000_0013);
    check({t, "_a1"}, get_a(1), 32'd1);
    check({t, "_d1"}, get_d(1), 32'h0010_0093);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  x;
    logic [31:0] w;
    rst = 1'b0;
    restart_i = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_we", 32'(rom_we_o), 32'd0);
    check("rst_waddr", 32'(rom_waddr_o), 32'd0);
    check("rst_wdata", rom_wdata_o, 32'd0);
    check("rst_core", 32'(core_rst_n_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_code", 32'(err_code_o), 32'd0);
    check("rst_ready", 32'(rx_ready_o), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;

    // Good two-word frame.
    send_frame1(8'h90);
    @(negedge clk);
    check_frame1_words("t1");
    check("t1_done", 32'(done_o), 32'd1);
    check("t1_core", 32'(core_rst_n_o), 32'd1);
    check("t1_code", 32'(err_code_o), 32'd0);
    check("t1_ready", 32'(rx_ready_o), 32'd0);

    // Restart, garbage before sync, same frame.
    pulse_restart();
    @(negedge clk);
    check("t2_rs_done", 32'(done_o), 32'd0);
    check("t2_rs_core", 32'(core_rst_n_o), 32'd0);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    send_frame1(8'h90);
    @(negedge clk);
    check_frame1_words("t2");
    check("t2_done", 32'(done_o), 32'd1);

    // Bad checksum: words still written, then error 1.
    pulse_restart();
    send_frame1(8'h81);
    @(negedge clk);
    check_frame1_words("t3");
    check("t3_err", 32'(err_o), 32'd1);
    check("t3_code", 32'(err_code_o), 32'd1);
    check("t3_core", 32'(core_rst_n_o), 32'd0);
    check("t3_done", 32'(done_o), 32'd0);

    // Length 17 > 16 words: error 2 right after LEN1.
    pulse_restart();
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h00);
    @(negedge clk);
    check("t4_err", 32'(err_o), 32'd1);
    check("t4_code", 32'(err_code_o), 32'd2);
    check("t4_nwr", 32'(wa_q.size()), 32'd0);

    // Full-capacity 16-word image; address wraps to 0 after the last write.
    pulse_restart();
    send_byte(8'hA5);
    send_byte(8'h10);
    send_byte(8'h00);
    x = 8'h00;
    for (int i = 0; i < 64; i++) begin
      send_byte(pat(i));
      x = x ^ pat(i);
    end
    send_byte(x);
    @(negedge clk);
    check("t4_full_nwr", 32'(wa_q.size()), 32'd16);
    for (int k = 0; k < 16; k++) begin
      w = {pat(4*k+3), pat(4*k+2), pat(4*k+1), pat(4*k)};
      check($sformatf("t4_a%0d", k), get_a(k), 32'(k));
      check($sformatf("t4_d%0d", k), get_d(k), w);
    end
    check("t4_done", 32'(done_o), 32'd1);
    check("t4_wrap", 32'(rom_waddr_o), 32'd0);

    // Timeout: 49 idle cycles is fine, the 50th trips error 3.
    pulse_restart();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    repeat (Tmo - 1) @(posedge clk);
    @(negedge clk);
    check("t5_early", 32'(err_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("t5_err", 32'(err_o), 32'd1);
    check("t5_code", 32'(err_code_o), 32'd3);
    check("t5_nwr", 32'(wa_q.size()), 32'd0);

    // Restart mid-DATA with a sync byte in the same cycle: byte must be dropped.
    pulse_restart();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h00);
    restart_i  = 1'b1;
    rx_valid_i = 1'b1;
    rx_data_i  = 8'hA5;
    @(posedge clk);
    #1;
    restart_i  = 1'b0;
    rx_valid_i = 1'b0;
    @(negedge clk);
    check("t6_waddr", 32'(rom_waddr_o), 32'd0);
    check("t6_ready", 32'(rx_ready_o), 32'd1);
    check("t6_nwr", 32'(wa_q.size()), 32'd0);
    send_frame1(8'h90);
    @(negedge clk);
    check_frame1_words("t6");
    check("t6_done", 32'(done_o), 32'd1);

    // Async reset mid-frame after one word has been written.
    pulse_restart();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h93);
    check("t6_pre_waddr", 32'(rom_waddr_o), 32'd1);
    rst = 1'b0;
    #1;
    check("t6_rst_we", 32'(rom_we_o), 32'd0);
    check("t6_rst_waddr", 32'(rom_waddr_o), 32'd0);
    check("t6_rst_wdata", rom_wdata_o, 32'd0);
    check("t6_rst_core", 32'(core_rst_n_o), 32'd0);
    check("t6_rst_done", 32'(done_o), 32'd0);
    check("t6_rst_err", 32'(err_o), 32'd0);
    check("t6_rst_code", 32'(err_code_o), 32'd0);
    check("t6_rst_ready", 32'(rx_ready_o), 32'd1);
    check("we_b2b", 32'(b2b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
